// File: rtl/triangle_pkg.sv
// rtl/triangle_pkg.sv - shared types and width helpers for the triangle rasteriser
//
// Contents:
//   state_e      controller states
//   orient_e     sign class of the triangle's signed area (zero = degenerate)
//   edge_width   width of an edge-function value for a given coordinate width
//   diff_width   width of a signed coordinate difference

package triangle_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD1 = 3'd1,
    ST_LOAD2 = 3'd2,
    ST_SETUP = 3'd3,
    ST_SCAN  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ORIENT_ZERO = 2'd0,
    ORIENT_POS  = 2'd1,
    ORIENT_NEG  = 2'd2
  } orient_e;

  function automatic int edge_width(input int cw);
    return 2 * cw + 3;
  endfunction

  function automatic int diff_width(input int cw);
    return cw + 1;
  endfunction

endpackage

// File: rtl/triangle_raster_if.sv
// rtl/triangle_raster_if.sv - vertex-in / point-out bundle of the triangle rasteriser
//
// Signals:
//   nt      new-triangle strobe (source -> rasteriser)
//   xi, yi  vertex coordinate (source -> rasteriser)
//   busy    loading or scanning
//   po      xo/yo is inside the triangle
//   xo, yo  current candidate point
//   done    one-cycle end-of-triangle pulse
// Modports: master = vertex source / point sink, slave = rasteriser.

interface triangle_raster_if #(
  parameter int CW = 3
);
  logic          nt;
  logic [CW-1:0] xi;
  logic [CW-1:0] yi;
  logic          busy;
  logic          po;
  logic [CW-1:0] xo;
  logic [CW-1:0] yo;
  logic          done;

  modport master (output nt, xi, yi, input busy, po, xo, yo, done);
  modport slave  (input nt, xi, yi, output busy, po, xo, yo, done);
endinterface

// File: rtl/triangle_edge_eval.sv
// rtl/triangle_edge_eval.sv - combinational edge function of a point against edge a->b
//
// Ports:
//   px, py  point under test
//   ax, ay  edge start vertex
//   bx, by  edge end vertex
//   e       (px-ax)*(by-ay) - (py-ay)*(bx-ax), full precision, signed

module triangle_edge_eval
  import triangle_pkg::*;
#(
  parameter int CW = 3,
  localparam int EW = edge_width(CW)
) (
  input  logic [CW-1:0]        px,
  input  logic [CW-1:0]        py,
  input  logic [CW-1:0]        ax,
  input  logic [CW-1:0]        ay,
  input  logic [CW-1:0]        bx,
  input  logic [CW-1:0]        by,
  output logic signed [EW-1:0] e
);

  localparam int DW = diff_width(CW);
  localparam int PW = 2 * DW;

  logic signed [DW-1:0] dpx, dpy, dbx, dby;
  logic signed [PW-1:0] prod_a, prod_b;

  assign dpx = $signed({1'b0, px}) - $signed({1'b0, ax});
  assign dpy = $signed({1'b0, py}) - $signed({1'b0, ay});
  assign dbx = $signed({1'b0, bx}) - $signed({1'b0, ax});
  assign dby = $signed({1'b0, by}) - $signed({1'b0, ay});

  // Widen before multiplying so neither product nor difference can overflow.
  assign prod_a = PW'(dpx) * PW'(dby);
  assign prod_b = PW'(dpy) * PW'(dbx);
  assign e      = EW'(prod_a) - EW'(prod_b);

endmodule

// File: rtl/triangle_raster.sv
// rtl/triangle_raster.sv - emits every grid point of a triangle, one bounding-box candidate per cycle
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    triangle_raster_if.slave: nt/xi/yi in, busy/po/xo/yo/done out
// Build option:
//   TRI_EDGE_INCL_EN  defined: points on an edge or vertex count as inside;
//                     undefined: strictly interior points only.

module triangle_raster
  import triangle_pkg::*;
#(
  parameter int CW = 3
) (
  input  logic             clk,
  input  logic             reset,
  triangle_raster_if.slave bus
);

  localparam int EW = edge_width(CW);

  state_e               state, state_nx;
  orient_e              orient;
  logic [CW-1:0]        ax, ay, bx, by, cx, cy;
  logic [CW-1:0]        xmin, xmax, ymin, ymax;
  logic [CW-1:0]        bb_xmin, bb_xmax, bb_ymin, bb_ymax;
  logic [CW-1:0]        x, y;
  logic                 run;
  logic                 last, hit, pos_ok, neg_ok;
  logic signed [EW-1:0] e_ab, e_bc, e_ca, e_tri;
  logic                 ab_neg, bc_neg, ca_neg, ab_zero, bc_zero, ca_zero;

  function automatic logic [CW-1:0] min3(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                         input logic [CW-1:0] c);
    logic [CW-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic [CW-1:0] max3(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                         input logic [CW-1:0] c);
    logic [CW-1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  assign bb_xmin = min3(ax, bx, cx);
  assign bb_xmax = max3(ax, bx, cx);
  assign bb_ymin = min3(ay, by, cy);
  assign bb_ymax = max3(ay, by, cy);

  triangle_edge_eval #(.CW(CW)) u_e_ab (.px(x), .py(y), .ax(ax), .ay(ay), .bx(bx), .by(by), .e(e_ab));
  triangle_edge_eval #(.CW(CW)) u_e_bc (.px(x), .py(y), .ax(bx), .ay(by), .bx(cx), .by(cy), .e(e_bc));
  triangle_edge_eval #(.CW(CW)) u_e_ca (.px(x), .py(y), .ax(cx), .ay(cy), .bx(ax), .by(ay), .e(e_ca));

  // E_AB evaluated at C is the negated twice-area; interior points carry
  // this sign on all three edges whatever the winding, and zero means
  // the vertices are collinear.
  triangle_edge_eval #(.CW(CW)) u_e_tri (.px(cx), .py(cy), .ax(ax), .ay(ay), .bx(bx), .by(by), .e(e_tri));

  assign ab_neg  = e_ab[EW-1];
  assign bc_neg  = e_bc[EW-1];
  assign ca_neg  = e_ca[EW-1];
  assign ab_zero = (e_ab == '0);
  assign bc_zero = (e_bc == '0);
  assign ca_zero = (e_ca == '0);

`ifdef TRI_EDGE_INCL_EN
  assign pos_ok = !ab_neg && !bc_neg && !ca_neg;
  assign neg_ok = (ab_neg || ab_zero) && (bc_neg || bc_zero) && (ca_neg || ca_zero);
`else
  assign pos_ok = !ab_neg && !ab_zero && !bc_neg && !bc_zero && !ca_neg && !ca_zero;
  assign neg_ok = ab_neg && bc_neg && ca_neg;
`endif

  assign hit  = ((orient == ORIENT_POS) && pos_ok) || ((orient == ORIENT_NEG) && neg_ok);
  assign last = (x == xmax) && (y == ymax);

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (bus.nt) state_nx = ST_LOAD1;
      ST_LOAD1: state_nx = ST_LOAD2;
      ST_LOAD2: state_nx = ST_SETUP;
      ST_SETUP: state_nx = (e_tri == '0) ? ST_DONE : ST_SCAN;
      ST_SCAN:  if (run && last) state_nx = ST_DONE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      orient   <= ORIENT_ZERO;
      {ax, ay, bx, by, cx, cy} <= '0;
      {xmin, xmax, ymin, ymax} <= '0;
      x        <= '0;
      y        <= '0;
      run      <= 1'b0;
      bus.busy <= 1'b0;
      bus.po   <= 1'b0;
      bus.xo   <= '0;
      bus.yo   <= '0;
      bus.done <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: if (bus.nt) begin
          ax <= bus.xi;
          ay <= bus.yi;
        end
        ST_LOAD1: begin
          bx <= bus.xi;
          by <= bus.yi;
        end
        ST_LOAD2: begin
          cx <= bus.xi;
          cy <= bus.yi;
        end
        ST_SETUP: begin
          xmin   <= bb_xmin;
          xmax   <= bb_xmax;
          ymin   <= bb_ymin;
          ymax   <= bb_ymax;
          orient <= (e_tri == '0) ? ORIENT_ZERO : (e_tri[EW-1] ? ORIENT_NEG : ORIENT_POS);
          run    <= 1'b0;
        end
        ST_SCAN: begin
          // First SCAN cycle only seeds the counter from the registered box.
          if (!run) begin
            x   <= xmin;
            y   <= ymin;
            run <= 1'b1;
          end else if (x == xmax) begin
            x <= xmin;
            y <= y + 1'b1;
          end else begin
            x <= x + 1'b1;
          end
        end
        default: ;
      endcase

      bus.busy <= (state inside {ST_LOAD1, ST_LOAD2, ST_SETUP, ST_SCAN});
      bus.done <= (state == ST_DONE);
      bus.po   <= (state == ST_SCAN) && run && hit;
      if ((state == ST_SCAN) && run) begin
        bus.xo <= x;
        bus.yo <= y;
      end
    end
  end

endmodule
